// File: rtl/calc_multi_pkg.sv
// calc_multi_pkg: shared definitions for the multi-accumulator calculator.
//   - ALU opcode encoding. calc_enc produces these codes and alu consumes them.
//   - hist_entry_t: one undo-history record {accumulator index, previous value}.
//     The record is sized for the largest legal configuration. Each user keeps
//     only the low bits that its own parameters need.
package calc_multi_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_MUL = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 3'b111;

    // The index field limits the design to at most 256 accumulators.
    localparam int HIST_IDX_W = 8;
    localparam int HIST_VAL_W = 32;

    typedef struct packed {
        logic [HIST_IDX_W-1:0] index;
        logic [HIST_VAL_W-1:0] value;
    } hist_entry_t;

endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit signed ALU.
//   op : opcode from calc_multi_pkg
//   a  : signed operand 1
//   b  : signed operand 2 (shift amount is b[4:0])
//   y  : result; products keep only their low 32 bits
module alu
    import calc_multi_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op,
    input  logic signed [31:0]  a,
    input  logic signed [31:0]  b,
    output logic signed [31:0]  y
);

    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_MUL: y = a * b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << b[4:0];
            default: y = a >>> b[4:0];
        endcase
    end

endmodule

// File: rtl/calc_enc.sv
// calc_enc: maps the three opcode-select buttons to an ALU opcode.
//   btnl, btnc, btnr : opcode-select buttons (level, not edge)
//   alu_op           : opcode; {btnl,btnc,btnr} = 000 ADD, 001 SUB, 010 MUL,
//                      011 AND, 100 OR, 101 XOR, 110 SLL, 111 SRA
module calc_enc
    import calc_multi_pkg::*;
(
    input  logic                btnc,
    input  logic                btnl,
    input  logic                btnr,
    output logic [ALU_OP_W-1:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        unique case ({btnl, btnc, btnr})
            3'b000:  alu_op = ALU_ADD;
            3'b001:  alu_op = ALU_SUB;
            3'b010:  alu_op = ALU_MUL;
            3'b011:  alu_op = ALU_AND;
            3'b100:  alu_op = ALU_OR;
            3'b101:  alu_op = ALU_XOR;
            3'b110:  alu_op = ALU_SLL;
            default: alu_op = ALU_SRA;
        endcase
    end

endmodule

// File: rtl/calc_hist.sv
// calc_hist: circular LIFO that holds undo history.
//   clk, resetn : clock; asynchronous active-low reset (clears pointer and count)
//   push, din   : store din as the newest entry. When the LIFO is full, the
//                 oldest entry is overwritten.
//   pop         : discard the newest entry (ignored when empty)
//   top         : the newest entry; valid only when empty is low
//   full, empty : count == HDEPTH, count == 0
//   count       : number of valid entries
module calc_hist
    import calc_multi_pkg::*;
#(
    parameter int HDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      push,
    input  logic                      pop,
    input  hist_entry_t               din,
    output hist_entry_t               top,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(HDEPTH):0]   count
);

    localparam int PW = $clog2(HDEPTH);
    localparam int CW = PW + 1;

    hist_entry_t    mem [HDEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  top_ptr;

    // wr_ptr always wraps because HDEPTH is a power of two. Once the LIFO is
    // full, a push lands on the oldest slot, which is the overwrite we want.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!full)
                count <= count + 1'b1;
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - 1'b1;
            count  <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    assign top_ptr = wr_ptr - 1'b1;
    assign top     = mem[top_ptr];
    assign full    = (count == CW'(HDEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/calc_multi.sv
// calc_multi: button-driven calculator with NACC accumulators and undo history.
//   clk, resetn       : clock; asynchronous active-low reset
//   btnc, btnl, btnr  : opcode select (see calc_enc)
//   btnd              : execute, acc[acc_sel] <= acc[acc_sel] op sw
//   btnu              : clear, acc[acc_sel] <= 0
//   btn_undo          : restore the newest history entry
//   acc_sel           : active accumulator
//   sw                : signed operand 2
//   led, zero         : acc[acc_sel] and (led == 0)
//   hist_count/full/empty : undo history occupancy
module calc_multi
    import calc_multi_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NACC   = 4,
    parameter int HDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      btnc,
    input  logic                      btnl,
    input  logic                      btnr,
    input  logic                      btnd,
    input  logic                      btnu,
    input  logic                      btn_undo,
    input  logic [$clog2(NACC)-1:0]   acc_sel,
    input  logic [WIDTH-1:0]          sw,
    output logic [WIDTH-1:0]          led,
    output logic                      zero,
    output logic [$clog2(HDEPTH):0]   hist_count,
    output logic                      hist_full,
    output logic                      hist_empty
);

    localparam int SELW = $clog2(NACC);

    logic [WIDTH-1:0]     acc [NACC];
    logic                 btnd_q, btnu_q, undo_q, armed;
    logic                 clr_edge, exe_edge, undo_edge;
    logic                 clr_fire, exe_fire, undo_fire;
    logic [ALU_OP_W-1:0]  alu_op;
    logic signed [31:0]   op1, op2, alu_res;
    hist_entry_t          push_entry, pop_entry;
    logic                 wr_en;
    logic [SELW-1:0]      wr_idx;
    logic [WIDTH-1:0]     wr_val;
    logic                 unused_bits;

    // armed is low for the first clock after reset. A button that is already
    // held when reset releases is sampled into its edge flop on that clock
    // without firing. It then needs a release and a new press to fire.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btnd_q <= 1'b0;
            btnu_q <= 1'b0;
            undo_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            btnd_q <= btnd;
            btnu_q <= btnu;
            undo_q <= btn_undo;
            armed  <= 1'b1;
        end
    end

    assign clr_edge  = armed & btnu & ~btnu_q;
    assign exe_edge  = armed & btnd & ~btnd_q;
    assign undo_edge = armed & btn_undo & ~undo_q;

    // Priority is clear > execute > undo. Edges that lose are dropped, not
    // deferred.
    assign clr_fire  = clr_edge;
    assign exe_fire  = exe_edge & ~clr_edge;
    assign undo_fire = undo_edge & ~clr_edge & ~exe_edge & ~hist_empty;

    assign led  = acc[acc_sel];
    assign zero = (led == '0);

    assign op1 = 32'(signed'(led));
    assign op2 = 32'(signed'(sw));

    calc_enc u_enc (
        .btnc   (btnc),
        .btnl   (btnl),
        .btnr   (btnr),
        .alu_op (alu_op)
    );

    alu u_alu (
        .op (alu_op),
        .a  (op1),
        .b  (op2),
        .y  (alu_res)
    );

    assign push_entry.index = HIST_IDX_W'(acc_sel);
    assign push_entry.value = HIST_VAL_W'(led);

    calc_hist #(.HDEPTH(HDEPTH)) u_hist (
        .clk    (clk),
        .resetn (resetn),
        .push   (clr_fire | exe_fire),
        .pop    (undo_fire),
        .din    (push_entry),
        .top    (pop_entry),
        .full   (hist_full),
        .empty  (hist_empty),
        .count  (hist_count)
    );

    // An undo writes to the accumulator stored in the entry, not to acc_sel.
    always_comb begin
        wr_en  = clr_fire | exe_fire | undo_fire;
        wr_idx = acc_sel;
        wr_val = '0;
        if (exe_fire) begin
            wr_val = alu_res[WIDTH-1:0];
        end else if (undo_fire) begin
            wr_idx = pop_entry.index[SELW-1:0];
            wr_val = pop_entry.value[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NACC; i++)
                acc[i] <= '0;
        end else if (wr_en) begin
            acc[wr_idx] <= wr_val;
        end
    end

    // The ALU's upper result bits and the spare history-field bits are
    // discarded on purpose. Folding them here marks them as intentionally
    // unused.
    assign unused_bits = ^{alu_res, pop_entry};

endmodule

// File: tb/tb_calc_multi.sv
module tb_calc_multi;

    logic        clk = 1'b0;
    logic        resetn;
    logic        btnc, btnl, btnr, btnd, btnu, btn_undo;
    logic [1:0]  acc_sel;
    logic [15:0] sw;
    logic [15:0] led;
    logic        zero;
    logic [3:0]  hist_count;
    logic        hist_full, hist_empty;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [15:0] led;
        logic [3:0]  cnt;
    } exp_t;

    exp_t q[$];

    calc_multi #(.WIDTH(16), .NACC(4), .HDEPTH(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .btnc       (btnc),
        .btnl       (btnl),
        .btnr       (btnr),
        .btnd       (btnd),
        .btnu       (btnu),
        .btn_undo   (btn_undo),
        .acc_sel    (acc_sel),
        .sw         (sw),
        .led        (led),
        .zero       (zero),
        .hist_count (hist_count),
        .hist_full  (hist_full),
        .hist_empty (hist_empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation; the monitor compares it at the next falling edge.
    task automatic chk(input string name, input logic [15:0] e_led, input logic [3:0] e_cnt);
        exp_t e;
        e.name = name;
        e.led  = e_led;
        e.cnt  = e_cnt;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // One press-and-release: a cycle with the buttons high, then an idle cycle.
    task automatic act(input logic u, input logic d, input logic z);
        btnu = u; btnd = d; btn_undo = z;
        step();
        btnu = 1'b0; btnd = 1'b0; btn_undo = 1'b0;
        step();
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                logic e_zero, e_full, e_empty;
                e       = q.pop_front();
                e_zero  = (e.led == 16'h0);
                e_full  = (e.cnt == 4'd8);
                e_empty = (e.cnt == 4'd0);
                checks++;
                if (led !== e.led || zero !== e_zero || hist_count !== e.cnt ||
                    hist_full !== e_full || hist_empty !== e_empty) begin
                    errors++;
                    $display("FAIL %s: got led=%h zero=%b cnt=%0d full=%b empty=%b, want led=%h zero=%b cnt=%0d full=%b empty=%b",
                             e.name, led, zero, hist_count, hist_full, hist_empty,
                             e.led, e_zero, e.cnt, e_full, e_empty);
                end
            end
        end
    end

    initial begin : stimulus
        resetn = 1'b0;
        btnc = 0; btnl = 0; btnr = 0; btnd = 0; btnu = 0; btn_undo = 0;
        acc_sel = 2'd0;
        sw = 16'd0;
        step();
        chk("reset", 16'h0000, 4'd0);
        resetn = 1'b1;
        step();

        // Basic execute, then clear.
        sw = 16'd5;
        act(0, 1, 0);
        chk("add5", 16'h0005, 4'd1);
        act(1, 0, 0);
        chk("clear", 16'h0000, 4'd2);

        // A held execute fires once.
        sw = 16'd1;
        btnd = 1'b1;
        step();
        chk("hold_first", 16'h0001, 4'd3);
        repeat (9) step();
        chk("hold_last", 16'h0001, 4'd3);
        btnd = 1'b0;
        step();

        // Wrap-around, then undo.
        sw = 16'h7FFE;
        act(0, 1, 0);
        chk("to_7fff", 16'h7FFF, 4'd4);
        sw = 16'h0001;
        act(0, 1, 0);
        chk("wrap", 16'h8000, 4'd5);
        act(0, 0, 1);
        chk("undo_wrap", 16'h7FFF, 4'd4);

        // An undo targets the stored index, not acc_sel.
        acc_sel = 2'd2;
        sw = 16'd3;
        act(0, 1, 0);
        chk("acc2_add3", 16'h0003, 4'd5);
        acc_sel = 2'd0;
        chk("sel0_view", 16'h7FFF, 4'd5);
        act(0, 0, 1);
        chk("undo_other_acc", 16'h7FFF, 4'd4);
        acc_sel = 2'd2;
        chk("acc2_restored", 16'h0000, 4'd4);

        // Priority: clear beats execute; execute beats undo.
        act(1, 1, 0);
        chk("clr_over_exe", 16'h0000, 4'd5);
        act(0, 1, 1);
        chk("exe_over_undo", 16'h0003, 4'd6);

        // Opcode encodings with sign extension.
        btnr = 1'b1; sw = 16'd5;
        act(0, 1, 0);
        chk("sub", 16'hFFFE, 4'd7);
        btnr = 1'b0; btnc = 1'b1; sw = 16'hFFFD;
        act(0, 1, 0);
        chk("mul_neg", 16'h0006, 4'd8);
        btnc = 1'b0; btnl = 1'b1; btnr = 1'b1; sw = 16'h000F;
        act(0, 1, 0);
        chk("xor_full", 16'h0009, 4'd8);
        btnl = 1'b0; btnr = 1'b0;

        // A full history overwrites its oldest entry: 9 executes, then 9 undos.
        step();
        resetn = 1'b0;
        #1;
        chk("reset2", 16'h0000, 4'd0);
        resetn = 1'b1;
        acc_sel = 2'd0;
        sw = 16'd1;
        step();
        for (int i = 1; i <= 9; i++) begin
            act(0, 1, 0);
            chk($sformatf("exec%0d", i), 16'(i), (i > 8) ? 4'd8 : 4'(i));
        end
        for (int k = 1; k <= 9; k++) begin
            act(0, 0, 1);
            chk($sformatf("undo%0d", k), (k <= 8) ? 16'(9 - k) : 16'd1,
                (k <= 8) ? 4'(8 - k) : 4'd0);
        end

        // Reset acts asynchronously, in the middle of a cycle.
        acc_sel = 2'd1;
        sw = 16'd9;
        act(0, 1, 0);
        sw = 16'd0;
        repeat (4) act(0, 1, 0);
        chk("pre_rst", 16'h0009, 4'd5);
        step();
        resetn = 1'b0;
        #1;
        chk("async_rst_acc1", 16'h0000, 4'd0);
        acc_sel = 2'd0;
        chk("async_rst_acc0", 16'h0000, 4'd0);
        acc_sel = 2'd3;
        chk("async_rst_acc3", 16'h0000, 4'd0);

        // A button held across reset release does not fire until it is pressed again.
        acc_sel = 2'd0;
        sw = 16'd7;
        btnd = 1'b1;
        step();
        resetn = 1'b1;
        repeat (3) step();
        chk("held_no_fire", 16'h0000, 4'd0);
        btnd = 1'b0;
        step();
        btnd = 1'b1;
        step();
        chk("repress", 16'h0007, 4'd1);
        btnd = 1'b0;
        step();

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: pending=%0d, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
